// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS memory arbiter: requester indices and
// default geometry / starvation limit.
package mips_mem_pkg;

    localparam int REQ_HOST  = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_FETCH = 2;
    localparam int NUM_REQ   = 3;

    localparam int DEF_AW           = 10;
    localparam int DEF_DW           = 32;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant pick: host always wins; a promoted fetch beats data;
// otherwise data beats fetch. Fetch is invisible while the core is halted.
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               halted,
    input  logic               promote,
    output logic [NUM_REQ-1:0] gnt
);

    logic fetch_live;

    assign fetch_live = req[REQ_FETCH] & ~halted;

    // Fixed priority with a single promotion override for fetch.
    always_comb begin
        gnt = '0;
        if (req[REQ_HOST])
            gnt[REQ_HOST] = 1'b1;
        else if (fetch_live && promote)
            gnt[REQ_FETCH] = 1'b1;
        else if (req[REQ_DATA])
            gnt[REQ_DATA] = 1'b1;
        else if (fetch_live)
            gnt[REQ_FETCH] = 1'b1;
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Three-way arbiter in front of a synchronous single-port memory. Grants are
// combinational, the memory command is registered one cycle later, and read
// responses come back two cycles after the grant tagged by requester.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
    input  logic                  halted,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]      starve_cnt;
    logic               promote;
    logic [NUM_REQ-1:0] req_live;
    logic               cmd_we;
    logic [AW-1:0]      cmd_addr;
    logic [DW-1:0]      cmd_wdata;
    // [0]: command issued to memory this cycle, [1]: data on mem_rdata now
    logic [1:0][NUM_REQ-1:0] tag_pipe;

    assign promote  = (starve_cnt == CW'(STARVE_LIMIT));
    // Requests are ignored while in reset so gnt reads zero.
    assign req_live = rst_n ? req : '0;

    mem_arb_pick u_pick (
        .req     (req_live),
        .halted  (halted),
        .promote (promote),
        .gnt     (gnt)
    );

    // Mux the granted requester's command (gnt is one-hot or zero).
    always_comb begin
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                cmd_we    = we[i];
                cmd_addr  = addr[i*AW +: AW];
                cmd_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // Count consecutive denied fetch cycles; saturate so a host-blocked
    // promoted fetch keeps its promotion.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (req[REQ_FETCH] && !gnt[REQ_FETCH] && !halted) begin
            if (!promote)
                starve_cnt <= starve_cnt + CW'(1);
        end else
            starve_cnt <= '0;
    end

    // Register the granted command toward memory; address/data hold when idle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= |gnt;
            mem_we <= (|gnt) & cmd_we;
            if (|gnt) begin
                mem_addr  <= cmd_addr;
                mem_wdata <= cmd_wdata;
            end
        end
    end

    // Read tags follow the command through memory latency; reset drops them.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            tag_pipe <= '0;
        else begin
            tag_pipe[0] <= gnt & ~we;
            tag_pipe[1] <= tag_pipe[0];
        end
    end

    assign rvalid = tag_pipe[1];
    assign rdata  = (|tag_pipe[1]) ? mem_rdata : '0;

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied fetch cycles before fetch is promoted.
REQ-004 clk1  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req  in  3  request per requester; bit0 host loader, bit1 data (MEM stage), bit2 instruction fetch.
REQ-007 we  in  3  per-requester write enable, valid while matching req bit high.
REQ-008 addr  in  3*AW  per-requester word address, slice i = requester i.
REQ-009 wdata  in  3*DW  per-requester write data, slice i = requester i.
REQ-010 halted  in  1  processor halted; masks fetch requests.
REQ-011 gnt  out  3  one-hot-or-zero grant, combinational from current inputs and state.
REQ-012 rvalid  out  3  one-hot-or-zero read-response strobe.
REQ-013 rdata  out  DW  read data shared by all requesters, valid when any rvalid bit high.
REQ-014 mem_en, mem_we  out  1 each  registered command to synchronous single-port memory.
REQ-015 mem_addr  out  AW; mem_wdata  out  DW  registered command address/data.
REQ-016 mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-017 At most one gnt bit SHALL be high per cycle; gnt[i] high only when req[i] high.
REQ-018 Priority SHALL be host > data > fetch, except a promoted fetch beats data but never host.
REQ-019 Fetch SHALL be promoted when starve_cnt == STARVE_LIMIT.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle req[2] && !gnt[2] && !halted, and clear on gnt[2], on !req[2], or on halted.
REQ-021 halted=1 SHALL force gnt[2]=0 regardless of req[2].
REQ-022 Granted command in cycle N SHALL appear on mem_* in cycle N+1 with mem_en=1; mem_en=0 in cycles with no grant.
REQ-023 For a granted read in cycle N, rvalid[i]=1 and rdata=mem_rdata SHALL occur in cycle N+2, for exactly one cycle.
REQ-024 Writes SHALL produce no rvalid; gnt is the only acknowledgement.
REQ-025 Requester SHALL hold req/we/addr/wdata until the cycle gnt is seen; grants SHALL be issuable back-to-back every cycle, with up to two reads in flight, each response tagged with its requester index.
REQ-026 A write followed by a read to the same address in the next grant cycle SHALL return the written data (memory ordering preserved, no reordering).

Reset
REQ-027 While rst_n=0: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, starve_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight read tags; no rvalid SHALL fire for commands granted before reset.
REQ-029 First grant SHALL be possible in the first cycle after rst_n deasserts.

Structure
REQ-030 Package mips_mem_pkg SHALL hold requester index constants (REQ_HOST=0, REQ_DATA=1, REQ_FETCH=2), default AW/DW and STARVE_LIMIT.
REQ-031 Sub-module mem_arb_pick SHALL implement the combinational priority/promotion pick; the top holds the starve counter, command registers and two-stage response tag pipeline.

Verification
REQ-032 req=3'b110, halted=0, both reads -> gnt=3'b010 first, fetch granted next cycle; rvalid[1] at N+2, rvalid[2] at N+3.
REQ-033 Data requests continuously with fetch pending, STARVE_LIMIT=4 -> fetch granted on 5th cycle, starve_cnt returns to 0.
REQ-034 Host writes addr 200 data 7, data reads addr 200 next cycle -> rvalid[1] with rdata=7 two cycles after data grant.
REQ-035 halted=1, req=3'b100 for 10 cycles -> gnt=0, mem_en=0 throughout; halted=0 -> gnt[2]=1 same cycle.
REQ-036 Fetch read granted, rst_n pulsed low next cycle -> rvalid stays 0, all outputs 0 during reset.
REQ-037 All three req high with starve_cnt=4 -> host granted, starve_cnt stays 4, fetch granted next cycle over data.
